inv_mixcol_seq: RTL
===================

// Module: inv_mixcol_seq
// PURPOSE
// - Sequences InvMixColumns over one 128-bit AES decryption state, COLS_PER_CYCLE columns per clock.
// - Time-shares a bank of GF(2^8) constant-multiply lookups (x09, x0B, x0D, x0E) across the four columns.
// - Sits in the AES_Decryption round datapath, between InvSubBytes/AddRoundKey and the next round.
// - Has a bypass path for the final round, which skips InvMixColumns.
// PARAMETERS
// - COLS_PER_CYCLE  1  columns processed per BUSY cycle; legal values 1, 2, 4; any other value is an elaboration error
// PORTS
// - clk        in   1    rising-edge clock
// - rst_n      in   1    asynchronous active-low reset
// - in_valid   in   1    in_data/in_bypass valid
// - in_ready   out  1    block can accept a state
// - in_data    in   128  state; bits [127:120] = row0,col0; column c = [127-32c -: 32], MSB byte = row0
// - in_bypass  in   1    1: pass the state through unchanged (final round)
// - out_valid  out  1    out_data valid
// - out_ready  in   1    downstream accepts out_data
// - out_data   out  128  result state, same byte order as in_data
// - busy       out  1    state != IDLE
// BEHAVIOUR
// - Reset (async, rst_n low):
//   - FSM returns to IDLE; out_valid=0, out_data=0, busy=0, column counter=0.
//   - in_ready=0 while rst_n is low; in_ready=1 from the first cycle after release.
//   - Reset mid-operation discards the in-flight state. No partial output is ever produced.
// - FSM states IDLE, BUSY, DONE.
//   - in_ready = (state==IDLE). Accept = in_valid & in_ready.
//   - IDLE, accept, in_bypass=0: capture in_data into the working register, col=0, go to BUSY.
//   - IDLE, accept, in_bypass=1: capture in_data, go directly to DONE.
//   - BUSY: each cycle transform columns col .. col+COLS_PER_CYCLE-1 in place; col += COLS_PER_CYCLE.
//   - BUSY: after the last group (col wraps to 0), go to DONE.
//   - DONE: out_valid=1 and out_data=working register, both held stable until out_ready.
//   - DONE, out_valid & out_ready: go to IDLE, out_valid=0 next cycle.
// - Column transform, with a0..a3 = rows 0..3 and ^ = XOR:
//   - b0 = E·a0 ^ B·a1 ^ D·a2 ^ 9·a3
//   - b1 = 9·a0 ^ E·a1 ^ B·a2 ^ D·a3
//   - b2 = D·a0 ^ 9·a1 ^ E·a2 ^ B·a3
//   - b3 = B·a0 ^ D·a1 ^ 9·a2 ^ E·a3
//   - Multiplies are in GF(2^8) mod x^8+x^4+x^3+x+1.
//   - The block instantiates exactly COLS_PER_CYCLE sets of the four multiplier LUTs.
// - Latency, accept edge to out_valid high:
//   - Transform: 1 + 4/COLS_PER_CYCLE cycles (5, 3 or 2).
//   - Bypass: 1 cycle.
// - Throughput:
//   - No new accept in the cycle of the output handshake; in_ready rises the cycle after.
//   - in_valid while not in_ready is ignored; upstream must hold it.
//   - out_ready low in DONE stalls indefinitely with no data loss.
// CONFIGURATION
// - IMC_ROUNDKEY_XOR_EN defined:
//   - Adds port rkey (in, 128).
//   - On accept, captures in_data ^ rkey for both the transform and the bypass paths (AddRoundKey fused ahead of InvMixColumns).
// - IMC_ROUNDKEY_XOR_EN undefined:
//   - No rkey port; in_data is captured unchanged.
// TESTING
// - Reset: rst_n low mid-BUSY -> next cycle out_valid=0, busy=0; after release in_ready=1 and no output appears.
// - FIPS vector: in_data=128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, bypass=0 -> out_data=128'hdb135345_f20a225c_01010101_d4d4d4d5.
// - Latency: the FIPS vector completes after 5/3/2 cycles for COLS_PER_CYCLE=1/2/4.
// - Bypass: in_data=128'h00112233_44556677_8899aabb_ccddeeff, bypass=1 -> identical out_data one cycle after accept.
// - Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, a pending in_valid is not accepted.
// - Back-to-back: two states with in_valid held high -> both accepted in order; the second accept occurs the cycle after the first output handshake.
// - Macro: with IMC_ROUNDKEY_XOR_EN, rkey = in_data, bypass=0 -> out_data=0.

Source files
------------

// File: rtl/inv_mixcol_seq.sv
// -----------------------------------------------------------------------------
// inv_mixcol_seq
//
// Sequential AES InvMixColumns over one 128-bit decryption state. A captured
// state is transformed in place, COLS_PER_CYCLE columns per clock, by a bank
// of GF(2^8) constant multipliers (x09, x0B, x0D, x0E) that is time-shared
// across the four columns. A bypass request (final decryption round) skips
// the transform and presents the captured state directly.
//
// Parameters
//   COLS_PER_CYCLE  columns transformed per BUSY cycle; 1, 2 or 4
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    in_data / in_bypass valid
//   in_ready   out  1    block can accept a state (IDLE, out of reset)
//   in_data    in   128  state; [127:120] = row0,col0; column c = [127-32c -: 32]
//   in_bypass  in   1    1: pass the state through unchanged
//   rkey       in   128  round key (only with IMC_ROUNDKEY_XOR_EN)
//   out_valid  out  1    out_data valid (DONE)
//   out_ready  in   1    downstream accepts out_data
//   out_data   out  128  result state, same byte order as in_data
//   busy       out  1    FSM not IDLE
//
// Optional build macro
//   IMC_ROUNDKEY_XOR_EN  adds the rkey port and captures in_data ^ rkey on
//                        accept (AddRoundKey fused ahead of InvMixColumns),
//                        for both the transform and the bypass path.
//
// Timing, counted in cycles after the accept edge until out_valid is high:
//   transform 1 + 4/COLS_PER_CYCLE (5, 3, 2), bypass 1.
// -----------------------------------------------------------------------------
module inv_mixcol_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
`ifdef IMC_ROUNDKEY_XOR_EN
  input  logic [127:0] rkey,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Column counter advances by COLS_PER_CYCLE modulo 4 (a step of 4 is 0, so
  // the single group always starts at column 0).
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  // Column index of the last group; finishing it completes the state.
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial x^8 + x^4 + x^3 + x + 1
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] m9;
    logic [7:0] mb;
    logic [7:0] md;
    logic [7:0] me;
  } mul_set_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // The four InvMixColumns constant products of one byte, built from the
  // x2/x4/x8 doubling chain: 9 = 8+1, B = 8+2+1, D = 8+4+1, E = 8+4+2.
  function automatic mul_set_t gf_mul_set(input logic [7:0] a);
    logic [7:0] a2;
    logic [7:0] a4;
    logic [7:0] a8;
    mul_set_t   m;
    a2   = xtime(a);
    a4   = xtime(a2);
    a8   = xtime(a4);
    m.m9 = a8 ^ a;
    m.mb = a8 ^ a2 ^ a;
    m.md = a8 ^ a4 ^ a;
    m.me = a8 ^ a4 ^ a2;
    return m;
  endfunction

  // One column: a0..a3 are rows 0..3, a0 in the MSB byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    mul_set_t m0;
    mul_set_t m1;
    mul_set_t m2;
    mul_set_t m3;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    m0 = gf_mul_set(c[31:24]);
    m1 = gf_mul_set(c[23:16]);
    m2 = gf_mul_set(c[15:8]);
    m3 = gf_mul_set(c[7:0]);
    b0 = m0.me ^ m1.mb ^ m2.md ^ m3.m9;
    b1 = m0.m9 ^ m1.me ^ m2.mb ^ m3.md;
    b2 = m0.md ^ m1.m9 ^ m2.me ^ m3.mb;
    b3 = m0.mb ^ m1.md ^ m2.m9 ^ m3.me;
    return {b0, b1, b2, b3};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Working register, one 32-bit word per column; index 0 is the MSB word,
  // matching the column numbering of in_data.
  logic [0:3][31:0] work_q;
  logic [1:0]       col_q;
  // Low during reset and until the first clock after release; keeps in_ready
  // deasserted while rst_n is low even though the FSM already sits in IDLE.
  logic             live_q;

  logic             accept;
  logic [127:0]     captured;
  logic [31:0]      lane_out [COLS_PER_CYCLE];

`ifdef IMC_ROUNDKEY_XOR_EN
  assign captured = in_data ^ rkey;
`else
  assign captured = in_data;
`endif

  assign in_ready  = (state_q == IDLE) && live_q;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  // Only a finished state is ever presented; partial results stay internal.
  assign out_data  = (state_q == DONE) ? work_q : '0;

  // ---------------------------------------------------------------------------
  // Multiplier bank: one column transform per lane. Lane l works on column
  // col_q + l (2-bit wrap is harmless: groups never straddle column 3).
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
    logic [1:0] idx;
    assign idx         = col_q + 2'(l);
    assign lane_out[l] = inv_mix_col(work_q[idx]);
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so every path drives state_d and no
    // latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)              state_d = in_bypass ? DONE : BUSY;
      BUSY: if (col_q == LAST_COL)   state_d = DONE;
      DONE: if (out_ready)           state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: capture and in-place column update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the working register is reset because out_data must read zero
      // after reset; it is a plain register, not an inferred memory.
      work_q <= '0;
      col_q  <= '0;
    end else begin
      if (accept) begin
        work_q <= captured;
        col_q  <= '0;
      end else if (state_q == BUSY) begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          work_q[col_q + 2'(i)] <= lane_out[i];
        end
        col_q <= col_q + COL_STEP;
      end
    end
  end

endmodule
